jls_frame_feeder: RTL and testbench

Synthesizable frame sequencer that sits between a pixel source and `jls_encoder`, replacing simulation-only image feeding with hardware. It latches a frame size, holds the encoder in reset for a programmable pre-gap, and streams exactly `width*height` pixels with a valid/ready handshake that tolerates bubbles. It then holds the encoder in reset for a post-gap and reports completion. Pixel depth and gap lengths are parametrised, and the block counts frames and flags illegal sizes.

---
 rtl/jls_pkg.sv | 10 +
 rtl/jls_raster_cnt.sv | 41 ++++
 rtl/jls_frame_feeder.sv | 128 ++++++++++++
 tb/tb_jls_frame_feeder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/jls_pkg.sv
// jls_pkg: shared constants and types for the JPEG-LS frame feeder and encoder.
//   MIN_WIDTH      smallest image width the encoder accepts
//   feeder_state_t frame sequencer states
package jls_pkg;

    localparam int MIN_WIDTH = 4;

    typedef enum logic [1:0] {IDLE, PRE, FEED, POST} feeder_state_t;

endpackage

// File: rtl/jls_raster_cnt.sv
// jls_raster_cnt: column/row position counter for a raster-scanned frame.
//   clk, rst   clock and synchronous active-high reset
//   clr        restart at column 0, row 0
//   inc        advance one pixel
//   width      image width, height image height (held stable while counting)
//   col, row   current pixel position
//   last       current position is the final pixel of the frame
module jls_raster_cnt #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] width,
    input  logic [15:0]  height,
    output logic [W-1:0] col,
    output logic [15:0]  row,
    output logic         last
);

    logic [W-1:0] col_q;
    logic [15:0]  row_q;
    logic         col_end;

    assign col_end = col_q == width - W'(1);
    assign last    = col_end && row_q == height - 16'd1;
    assign col     = col_q;
    assign row     = row_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col_q <= '0;
            row_q <= '0;
        end else if (inc) begin
            col_q <= col_end ? '0 : col_q + W'(1);
            row_q <= col_end ? row_q + 16'd1 : row_q;
        end
    end

endmodule

// File: rtl/jls_frame_feeder.sv
// jls_frame_feeder: sequences one frame into jls_encoder (pre-gap reset, pixel stream, post-gap reset).
//   clk, rst                  clock and synchronous active-high reset
//   start, width, height      frame request and size, sampled in IDLE
//   s_valid, s_ready, s_data  upstream pixel handshake
//   enc_rst, enc_ivalid, enc_idata  encoder control and pixel stream
//   busy, done, cfg_err       status: active, frame-end pulse, rejected-start pulse
//   frame_cnt                 completed frames, wraps
module jls_frame_feeder
    import jls_pkg::*;
#(
    parameter int MAXLEN_LEVEL = 12,
    parameter int PIX_WIDTH    = 8,
    parameter int PRE_GAP      = 400,
    parameter int POST_GAP     = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MAXLEN_LEVEL-1:0] width,
    input  logic [15:0]             height,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PIX_WIDTH-1:0]    s_data,
    output logic                    enc_rst,
    output logic                    enc_ivalid,
    output logic [PIX_WIDTH-1:0]    enc_idata,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic [15:0]             frame_cnt
);

    localparam int GAP_MAX = PRE_GAP > POST_GAP ? PRE_GAP : POST_GAP;
    localparam int GW      = $clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] PRE_LAST  = GW'(PRE_GAP - 1);
    // POST spans POST_GAP+1 cycles: the first still shows the last pixel with enc_rst low.
    localparam logic [GW-1:0] POST_LAST = GW'(POST_GAP);

    feeder_state_t         state_q, state_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [MAXLEN_LEVEL-1:0] width_q;
    logic [15:0]           height_q;
    logic                  s_ready_q, enc_rst_q, enc_ivalid_q, busy_q, done_q, cfg_err_q;
    logic                  s_ready_d, enc_rst_d, done_d, cfg_err_d;
    logic [PIX_WIDTH-1:0]  enc_idata_q;
    logic [15:0]           frame_cnt_q;
    logic                  hs, accept, last;
    logic [MAXLEN_LEVEL-1:0] col_unused;
    logic [15:0]           row_unused;

    jls_raster_cnt #(.W(MAXLEN_LEVEL)) u_raster (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .inc    (hs),
        .width  (width_q),
        .height (height_q),
        .col    (col_unused),
        .row    (row_unused),
        .last   (last)
    );

    always_comb begin
        hs        = state_q == FEED && s_valid;
        accept    = state_q == IDLE && start && width >= MAXLEN_LEVEL'(MIN_WIDTH) && height != 16'd0;
        cfg_err_d = state_q == IDLE && start && !accept;
        state_d   = state_q;
        gap_d     = gap_q;
        case (state_q)
            IDLE: begin
                state_d = accept ? PRE : IDLE;
                gap_d   = '0;
            end
            PRE: begin
                state_d = gap_q == PRE_LAST ? FEED : PRE;
                gap_d   = gap_q == PRE_LAST ? '0 : gap_q + GW'(1);
            end
            FEED: state_d = hs && last ? POST : FEED;
            POST: begin
                state_d = gap_q == POST_LAST ? IDLE : POST;
                gap_d   = gap_q == POST_LAST ? '0 : gap_q + GW'(1);
            end
        endcase
        s_ready_d = state_d == FEED;
        enc_rst_d = !(state_d == FEED || (state_d == POST && gap_d == '0));
        done_d    = state_d == POST && gap_d == POST_LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            width_q      <= '0;
            height_q     <= '0;
            s_ready_q    <= 1'b0;
            enc_rst_q    <= 1'b1;
            enc_ivalid_q <= 1'b0;
            enc_idata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            width_q      <= accept ? width : width_q;
            height_q     <= accept ? height : height_q;
            s_ready_q    <= s_ready_d;
            enc_rst_q    <= enc_rst_d;
            enc_ivalid_q <= hs;
            enc_idata_q  <= hs ? s_data : enc_idata_q;
            busy_q       <= state_d != IDLE;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            frame_cnt_q  <= frame_cnt_q + 16'(done_d);
        end
    end

    assign s_ready    = s_ready_q;
    assign enc_rst    = enc_rst_q;
    assign enc_ivalid = enc_ivalid_q;
    assign enc_idata  = enc_idata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_jls_frame_feeder.sv
// tb_jls_frame_feeder: directed, table-driven bench for jls_frame_feeder.
module tb_jls_frame_feeder;

    localparam int PRE  = 3;
    localparam int POST = 2;

    typedef struct {
        logic [11:0] w;
        logic [15:0] h;
        bit          toggle;
        bit          err;
        int          px;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, s_valid;
    logic [11:0] width;
    logic [15:0] height;
    logic [7:0]  s_data;
    logic        s_ready, enc_rst, enc_ivalid, busy, done, cfg_err;
    logic [7:0]  enc_idata;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    int exp_frames = 0;
    int pix = 10;
    vec_t vecs[6];

    always #5 clk = ~clk;

    jls_frame_feeder #(
        .MAXLEN_LEVEL (12),
        .PIX_WIDTH    (8),
        .PRE_GAP      (PRE),
        .POST_GAP     (POST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .width      (width),
        .height     (height),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .enc_rst    (enc_rst),
        .enc_ivalid (enc_ivalid),
        .enc_idata  (enc_idata),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .frame_cnt  (frame_cnt)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enc_rst"}, enc_rst, 1);
        chk({tag, "_enc_ivalid"}, enc_ivalid, 0);
        chk({tag, "_enc_idata"}, enc_idata, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // One frame request: rejected sizes check cfg_err, accepted ones check the whole
    // PRE/FEED/POST timeline. hold keeps start high; poke issues starts mid-frame.
    task automatic run_vec(input vec_t v, input bit hold, input bit poke);
        int tx, rx, u, dc;
        bit got_done;
        logic [7:0] base;
        base   = 8'(pix);
        start  = 1'b1;
        width  = v.w;
        height = v.h;
        tick;
        if (!hold) start = 1'b0;
        if (v.err) begin
            chk("rej_cfg_err", cfg_err, 1);
            chk("rej_busy", busy, 0);
            chk("rej_enc_rst", enc_rst, 1);
            tick;
            chk("rej_cfg_err_pulse", cfg_err, 0);
            chk("rej_busy_after", busy, 0);
            chk("rej_enc_rst_after", enc_rst, 1);
            return;
        end
        chk("start_busy", busy, 1);
        chk("start_cfg_err", cfg_err, 0);
        chk("pre_enc_rst", enc_rst, 1);
        chk("pre_s_ready", s_ready, 0);
        repeat (PRE - 1) begin
            tick;
            chk("pre_enc_rst", enc_rst, 1);
            chk("pre_s_ready", s_ready, 0);
        end
        tick;
        chk("feed_s_ready", s_ready, 1);
        chk("feed_enc_rst", enc_rst, 0);
        tx = 0;
        rx = 0;
        u = -10;
        dc = -1;
        got_done = 1'b0;
        for (int c = 0; c < 2 * v.px + POST + 10 && !got_done; c++) begin
            if (enc_ivalid) begin
                chk("pix_data", enc_idata, int'(8'(int'(base) + rx)));
                chk("pix_enc_rst", enc_rst, 0);
                rx++;
            end
            chk("no_cfg_err", cfg_err, 0);
            if (c == u + 1) begin
                chk("last_s_ready_drop", s_ready, 0);
                chk("last_ivalid", enc_ivalid, 1);
                chk("last_enc_rst", enc_rst, 0);
            end
            if (c == u + 2) chk("post_enc_rst", enc_rst, 1);
            if (done) begin
                got_done = 1'b1;
                dc = c;
                chk("done_frame_cnt", frame_cnt, (exp_frames + 1) % 65536);
                chk("done_enc_rst", enc_rst, 1);
                chk("done_busy", busy, 1);
            end
            s_valid = v.toggle ? (c % 2 == 0) : 1'b1;
            s_data  = 8'(int'(base) + tx);
            if (poke) begin
                start = (c == 1 || c == u + 2);
                width = 12'd3;
            end
            if (s_valid && s_ready) begin
                tx++;
                if (tx == v.px) u = c;
            end
            if (!got_done) tick;
        end
        s_valid = 1'b0;
        if (poke) begin
            start = 1'b0;
            width = v.w;
        end
        exp_frames++;
        chk("done_seen", got_done, 1);
        chk("done_time", dc, u + POST + 1);
        chk("px_accepted", tx, v.px);
        chk("px_forwarded", rx, v.px);
        tick;
        chk("end_busy", busy, 0);
        chk("end_done_pulse", done, 0);
        chk("end_frame_cnt", frame_cnt, exp_frames % 65536);
        pix += v.px;
    endtask

    initial begin
        vecs[0] = '{w: 12'd4, h: 16'd1, toggle: 1'b0, err: 1'b0, px: 4};
        vecs[1] = '{w: 12'd3, h: 16'd1, toggle: 1'b0, err: 1'b1, px: 0};
        vecs[2] = '{w: 12'd4, h: 16'd0, toggle: 1'b0, err: 1'b1, px: 0};
        vecs[3] = '{w: 12'd5, h: 16'd2, toggle: 1'b1, err: 1'b0, px: 10};
        vecs[4] = '{w: 12'd6, h: 16'd3, toggle: 1'b0, err: 1'b0, px: 18};
        vecs[5] = '{w: 12'd4, h: 16'd2, toggle: 1'b1, err: 1'b0, px: 8};

        rst = 1'b1;
        start = 1'b0;
        width = '0;
        height = '0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) tick;
        check_reset_outputs("rst");
        rst = 1'b0;
        tick;
        check_reset_outputs("idle");

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, 1'b0);

        run_vec('{w: 12'd5, h: 16'd2, toggle: 1'b0, err: 1'b0, px: 10}, 1'b0, 1'b1);

        // Reset in the middle of an 8x8 frame.
        start = 1'b1;
        width = 12'd8;
        height = 16'd8;
        tick;
        start = 1'b0;
        repeat (PRE) tick;
        chk("mid_feed_ready", s_ready, 1);
        s_valid = 1'b1;
        s_data = 8'hA5;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        s_valid = 1'b0;
        exp_frames = 0;
        check_reset_outputs("midrst");
        tick;
        chk("midrst_idle_busy", busy, 0);

        // Three back-to-back 4x1 frames with start held high.
        for (int i = 0; i < 3; i++)
            run_vec('{w: 12'd4, h: 16'd1, toggle: 1'b0, err: 1'b0, px: 4}, 1'b1, 1'b0);
        start = 1'b0;
        chk("b2b_frame_cnt", frame_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
